fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. Owns the program counter, drives it to the byte-addressed, big-endian instruction memory, and captures the returned word plus PC+4 into the IF/ID pipeline register. Handles pipeline stall, flush, and branch/jump redirect from downstream stages, and flags bad fetch addresses. Sits directly upstream of `instructionMemory` and feeds the decode stage.

---
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS core.
// Owns the program counter and drives it to the instruction memory.
// Captures the returned word and PC+4 into the IF/ID pipeline register.
// Applies stall, flush and branch/jump redirect from later stages.
// Raises sticky flags for redirect targets that are misaligned or out of range.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'd100,
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_instruction,
    output logic [31:0] PC,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        misaligned_err,
    output logic        range_err,
    output logic [15:0] fetch_count
);

    // MEM_BYTES is a power of two, so "mod MEM_BYTES" reduces to masking.
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    // Registered state.
    logic [31:0] pc_q,         pc_d;
    logic [31:0] instr_q,      instr_d;
    logic [31:0] pc_plus4_q,   pc_plus4_d;
    logic        valid_q,      valid_d;
    logic        misaligned_q, misaligned_d;
    logic        range_q,      range_d;
    logic [15:0] count_q,      count_d;

    // Intermediate combinational terms.
    logic [31:0] seq_pc;
    logic [31:0] redirect_target;
    logic        target_misaligned;
    logic        target_out_of_range;
    logic        squash_ifid;
    logic        capture_ifid;

    // Derive the sequential address, the redirect target and the per-edge IF/ID action.
    always_comb begin
        seq_pc              = (pc_q + 32'd4) & ADDR_MASK;
        // Low two bits are forced to zero first, then the address wraps into memory.
        redirect_target     = {redirect_pc[31:2], 2'b00} & ADDR_MASK;
        target_misaligned   = (redirect_pc[1:0] != 2'b00);
        target_out_of_range = (redirect_pc >= MEM_LIMIT);
        // A redirect squashes IF/ID even under stall; flush squashes independently of stall.
        squash_ifid         = redirect || flush;
        // A real instruction enters IF/ID only on a plain, un-stalled, un-flushed fetch.
        capture_ifid        = !redirect && !stall && !flush;
    end

    // Next PC: redirect wins over stall, stall holds, otherwise advance by one word.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (!stall) begin
            pc_d = seq_pc;
        end
    end

    // Next IF/ID contents: squash to a NOP, hold on stall, otherwise latch the fetched word.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (squash_ifid) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            instr_d    = imem_instruction;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b1;
        end
    end

    // Sticky error flags: set by a bad redirect target, cleared only by reset.
    always_comb begin
        misaligned_d = misaligned_q;
        range_d      = range_q;
        if (redirect) begin
            if (target_misaligned) begin
                misaligned_d = 1'b1;
            end
            if (target_out_of_range) begin
                range_d = 1'b1;
            end
        end
    end

    // Fetch counter: counts real captures into IF/ID, saturating at the top value.
    always_comb begin
        count_d = count_q;
        if (capture_ifid && (count_q != COUNT_MAX)) begin
            count_d = count_q + 16'd1;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_plus4_q   <= 32'd0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            range_q      <= 1'b0;
            count_q      <= 16'd0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_plus4_q   <= pc_plus4_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
            range_q      <= range_d;
            count_q      <= count_d;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        PC               = pc_q;
        ifid_instruction = instr_q;
        ifid_pc_plus4    = pc_plus4_q;
        ifid_valid       = valid_q;
        misaligned_err   = misaligned_q;
        range_err        = range_q;
        fetch_count      = count_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int unsigned MEM_BYTES = 16384;
    localparam int unsigned MEM_WORDS = MEM_BYTES / 4;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_instruction;
    logic [31:0] PC;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        misaligned_err;
    logic        range_err;
    logic [15:0] fetch_count;

    int n_total;
    int n_pass;

    // Instruction memory contents (word-indexed).
    logic [31:0] mem [0:MEM_WORDS-1];

    // Behavioural model state.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_mis;
    logic        m_rng;
    int          m_cnt;

    fetch_stage #(
        .RESET_PC (32'd100),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_instruction(imem_instruction),
        .PC              (PC),
        .ifid_instruction(ifid_instruction),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .ifid_valid      (ifid_valid),
        .misaligned_err  (misaligned_err),
        .range_err       (range_err),
        .fetch_count     (fetch_count)
    );

    // Combinational instruction memory.
    assign imem_instruction = mem[PC[13:2]];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc    = 32'd100;
        m_instr = 32'd0;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_rng   = 1'b0;
        m_cnt   = 0;
    endtask

    // Drive one cycle of inputs, advance the model, and settle 1 time unit after the edge.
    task automatic drive_edge(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
        logic [31:0] n_pc, n_instr, n_pc4;
        logic        n_valid, n_mis, n_rng;
        int          n_cnt;
        stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
        n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
        n_mis = m_mis; n_rng = m_rng; n_cnt = m_cnt;
        if (rd) begin
            n_pc = ((rpc / 4) * 4) % MEM_BYTES;
            n_instr = 0; n_pc4 = 0; n_valid = 0;
            if (rpc % 4 != 0) n_mis = 1;
            if (rpc >= MEM_BYTES) n_rng = 1;
        end else begin
            if (!st) n_pc = (m_pc + 4) % MEM_BYTES;
            if (fl) begin
                n_instr = 0; n_pc4 = 0; n_valid = 0;
            end else if (!st) begin
                n_instr = mem[m_pc / 4];
                n_pc4 = (m_pc + 4) % MEM_BYTES;
                n_valid = 1;
                if (m_cnt < 65535) n_cnt = m_cnt + 1;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
        m_mis = n_mis; m_rng = n_rng; m_cnt = n_cnt;
    endtask

    // Pulse reset away from the clock edge and release it on a falling edge.
    task automatic apply_reset();
        #2;
        rst = 1'b1;
        stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_total++; if (PC !== 32'd100) $display("FAIL reset_pc: got %0d want 100", PC); else n_pass++;
        n_total++; if (ifid_instruction !== 32'd0) $display("FAIL reset_instr: got %h want 0", ifid_instruction); else n_pass++;
        n_total++; if (ifid_pc_plus4 !== 32'd0) $display("FAIL reset_pc4: got %0d want 0", ifid_pc_plus4); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifid_valid); else n_pass++;
        n_total++; if ({misaligned_err, range_err} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {misaligned_err, range_err}); else n_pass++;
        n_total++; if (fetch_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", fetch_count); else n_pass++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_straight_line();
        drive_edge(0, 0, 0, 0);
        n_total++; if (ifid_instruction !== 32'h48080000) $display("FAIL straight_instr1: got %h want 48080000", ifid_instruction); else n_pass++;
        n_total++; if (ifid_pc_plus4 !== 32'd104) $display("FAIL straight_pc4_1: got %0d want 104", ifid_pc_plus4); else n_pass++;
        n_total++; if (ifid_valid !== 1'b1) $display("FAIL straight_valid1: got %b want 1", ifid_valid); else n_pass++;
        n_total++; if (PC !== 32'd104) $display("FAIL straight_pc1: got %0d want 104", PC); else n_pass++;
        drive_edge(0, 0, 0, 0);
        n_total++; if (ifid_instruction !== 32'h48090004) $display("FAIL straight_instr2: got %h want 48090004", ifid_instruction); else n_pass++;
        n_total++; if (PC !== 32'd108) $display("FAIL straight_pc2: got %0d want 108", PC); else n_pass++;
        n_total++; if (fetch_count !== 16'd2) $display("FAIL straight_count: got %0d want 2", fetch_count); else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive_edge(1, 0, 0, 0);
            n_total++; if (PC !== 32'd108) $display("FAIL stall_pc[%0d]: got %0d want 108", i, PC); else n_pass++;
            n_total++; if (ifid_instruction !== 32'h48090004) $display("FAIL stall_instr[%0d]: got %h want 48090004", i, ifid_instruction); else n_pass++;
            n_total++; if (fetch_count !== 16'd2) $display("FAIL stall_count[%0d]: got %0d want 2", i, fetch_count); else n_pass++;
        end
        drive_edge(0, 0, 0, 0);
        n_total++; if (ifid_instruction !== 32'h480A0008) $display("FAIL stall_release_instr: got %h want 480A0008", ifid_instruction); else n_pass++;
        n_total++; if (PC !== 32'd112) $display("FAIL stall_release_pc: got %0d want 112", PC); else n_pass++;
        n_total++; if (fetch_count !== 16'd3) $display("FAIL stall_release_count: got %0d want 3", fetch_count); else n_pass++;
    endtask

    task automatic test_redirect();
        drive_edge(0, 0, 1, 32'd500);
        n_total++; if (PC !== 32'd500) $display("FAIL redir_pc: got %0d want 500", PC); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL redir_valid: got %b want 0", ifid_valid); else n_pass++;
        n_total++; if (ifid_instruction !== 32'd0) $display("FAIL redir_instr: got %h want 0", ifid_instruction); else n_pass++;
        n_total++; if (fetch_count !== 16'd3) $display("FAIL redir_count: got %0d want 3", fetch_count); else n_pass++;
        drive_edge(0, 0, 0, 0);
        n_total++; if (ifid_instruction !== 32'h2413000F) $display("FAIL redir_target_instr: got %h want 2413000F", ifid_instruction); else n_pass++;
        n_total++; if (ifid_pc_plus4 !== 32'd504) $display("FAIL redir_target_pc4: got %0d want 504", ifid_pc_plus4); else n_pass++;
        n_total++; if (ifid_valid !== 1'b1) $display("FAIL redir_target_valid: got %b want 1", ifid_valid); else n_pass++;
    endtask

    task automatic test_redirect_stall_flush();
        drive_edge(1, 0, 1, 32'd600);
        n_total++; if (PC !== 32'd600) $display("FAIL rs_pc: got %0d want 600", PC); else n_pass++;
        n_total++; if ({ifid_valid, ifid_instruction} !== 33'd0) $display("FAIL rs_squash: got %b/%h want 0/0", ifid_valid, ifid_instruction); else n_pass++;
        n_total++; if (fetch_count !== 16'd4) $display("FAIL rs_count: got %0d want 4", fetch_count); else n_pass++;
        drive_edge(0, 0, 0, 0);
        n_total++; if (PC !== 32'd604) $display("FAIL rs_next_pc: got %0d want 604", PC); else n_pass++;
        n_total++; if (ifid_instruction !== mem[150]) $display("FAIL rs_next_instr: got %h want %h", ifid_instruction, mem[150]); else n_pass++;
        drive_edge(0, 1, 0, 0);
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", ifid_valid); else n_pass++;
        n_total++; if (PC !== 32'd608) $display("FAIL flush_pc: got %0d want 608", PC); else n_pass++;
        n_total++; if (ifid_pc_plus4 !== 32'd0) $display("FAIL flush_pc4: got %0d want 0", ifid_pc_plus4); else n_pass++;
        n_total++; if (fetch_count !== 16'd5) $display("FAIL flush_count: got %0d want 5", fetch_count); else n_pass++;
        drive_edge(1, 1, 0, 0);
        n_total++; if (PC !== 32'd608) $display("FAIL flush_stall_pc: got %0d want 608", PC); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL flush_stall_valid: got %b want 0", ifid_valid); else n_pass++;
    endtask

    task automatic test_errors();
        drive_edge(0, 0, 1, 32'd602);
        n_total++; if (PC !== 32'd600) $display("FAIL mis_pc: got %0d want 600", PC); else n_pass++;
        n_total++; if ({misaligned_err, range_err} !== 2'b10) $display("FAIL mis_flags: got %b want 10", {misaligned_err, range_err}); else n_pass++;
        drive_edge(0, 0, 1, 32'd16388);
        n_total++; if (PC !== 32'd4) $display("FAIL rng_pc: got %0d want 4", PC); else n_pass++;
        n_total++; if ({misaligned_err, range_err} !== 2'b11) $display("FAIL rng_flags: got %b want 11", {misaligned_err, range_err}); else n_pass++;
        for (int i = 0; i < 3; i++) drive_edge(0, 0, 0, 0);
        n_total++; if ({misaligned_err, range_err} !== 2'b11) $display("FAIL sticky_flags: got %b want 11", {misaligned_err, range_err}); else n_pass++;
        n_total++; if (PC !== 32'd16) $display("FAIL sticky_pc: got %0d want 16", PC); else n_pass++;
    endtask

    task automatic test_wrap_and_async_reset();
        apply_reset();
        drive_edge(0, 0, 1, 32'd16380);
        n_total++; if (PC !== 32'd16380) $display("FAIL wrap_target_pc: got %0d want 16380", PC); else n_pass++;
        drive_edge(0, 0, 0, 0);
        n_total++; if (PC !== 32'd0) $display("FAIL wrap_pc: got %0d want 0", PC); else n_pass++;
        n_total++; if (ifid_instruction !== mem[MEM_WORDS-1]) $display("FAIL wrap_instr: got %h want %h", ifid_instruction, mem[MEM_WORDS-1]); else n_pass++;
        n_total++; if (ifid_pc_plus4 !== 32'd0) $display("FAIL wrap_pc4: got %0d want 0", ifid_pc_plus4); else n_pass++;
        n_total++; if ({misaligned_err, range_err} !== 2'b00) $display("FAIL wrap_flags: got %b want 00", {misaligned_err, range_err}); else n_pass++;
        drive_edge(0, 0, 1, 32'd602);
        // Pending redirect plus asynchronous reset between edges.
        redirect = 1'b1; redirect_pc = 32'd1000; stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (PC !== 32'd100) $display("FAIL async_pc: got %0d want 100", PC); else n_pass++;
        n_total++; if ({ifid_valid, ifid_instruction, ifid_pc_plus4} !== 65'd0) $display("FAIL async_ifid: got %b/%h/%0d want 0", ifid_valid, ifid_instruction, ifid_pc_plus4); else n_pass++;
        n_total++; if ({misaligned_err, range_err} !== 2'b00) $display("FAIL async_flags: got %b want 00", {misaligned_err, range_err}); else n_pass++;
        n_total++; if (fetch_count !== 16'd0) $display("FAIL async_count: got %0d want 0", fetch_count); else n_pass++;
        model_reset();
        @(negedge clk);
        redirect = 0; stall = 0; redirect_pc = 0;
        rst = 1'b0;
        drive_edge(0, 0, 0, 0);
        n_total++; if (PC !== 32'd104) $display("FAIL post_reset_pc: got %0d want 104", PC); else n_pass++;
        n_total++; if (ifid_instruction !== 32'h48080000) $display("FAIL post_reset_instr: got %h want 48080000", ifid_instruction); else n_pass++;
    endtask

    task automatic test_random();
        logic        st, fl, rd;
        logic [31:0] rpc;
        int          kind;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 10);
            rd = ($urandom_range(0, 99) < 12);
            kind = $urandom_range(0, 3);
            case (kind)
                0: rpc = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
                1: rpc = 32'($urandom_range(0, MEM_BYTES - 1));
                2: rpc = $urandom;
                default: rpc = 32'd16380;
            endcase
            drive_edge(st, fl, rd, rpc);
            n_total++; if (PC !== m_pc) $display("FAIL rand_pc[%0d]: got %0d want %0d", i, PC, m_pc); else n_pass++;
            n_total++; if (ifid_instruction !== m_instr) $display("FAIL rand_instr[%0d]: got %h want %h", i, ifid_instruction, m_instr); else n_pass++;
            n_total++; if (ifid_pc_plus4 !== m_pc4) $display("FAIL rand_pc4[%0d]: got %0d want %0d", i, ifid_pc_plus4, m_pc4); else n_pass++;
            n_total++; if (ifid_valid !== m_valid) $display("FAIL rand_valid[%0d]: got %b want %b", i, ifid_valid, m_valid); else n_pass++;
            n_total++; if (misaligned_err !== m_mis) $display("FAIL rand_mis[%0d]: got %b want %b", i, misaligned_err, m_mis); else n_pass++;
            n_total++; if (range_err !== m_rng) $display("FAIL rand_rng[%0d]: got %b want %b", i, range_err, m_rng); else n_pass++;
            n_total++; if (fetch_count !== 16'(m_cnt)) $display("FAIL rand_count[%0d]: got %0d want %0d", i, fetch_count, m_cnt); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 65535; i++) drive_edge(0, 0, 0, 0);
        n_total++; if (fetch_count !== 16'hFFFF) $display("FAIL sat_reach: got %h want FFFF", fetch_count); else n_pass++;
        drive_edge(0, 0, 0, 0);
        n_total++; if (fetch_count !== 16'hFFFF) $display("FAIL sat_hold: got %h want FFFF", fetch_count); else n_pass++;
        n_total++; if (PC !== m_pc) $display("FAIL sat_pc: got %0d want %0d", PC, m_pc); else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[25]  = 32'h48080000;
        mem[26]  = 32'h48090004;
        mem[27]  = 32'h480A0008;
        mem[125] = 32'h2413000F;
        model_reset();

        test_reset();
        test_straight_line();
        test_stall();
        test_redirect();
        test_redirect_stall_flush();
        test_errors();
        test_wrap_and_async_reset();
        test_random();
        test_saturation();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
